// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Purpose  : Round-robin sharing of one SDRAM controller command port between
//            NUM_PORTS requesters, one outstanding transaction, with watchdog.
// Revision : 1.0
// ============================================================================
module sdram_port_arbiter #(
  parameter int NUM_PORTS         = 4,
  parameter int ADDRESS_WIDTH     = 22,
  parameter int DATA_WIDTH        = 16,
  parameter int READ_BURST_LENGTH = 1,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_PORTS-1:0]               req_valid,
  input  logic [NUM_PORTS-1:0]               req_write,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_PORTS-1:0]               req_ready,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  output logic [NUM_PORTS-1:0]               rsp_read_valid,
  output logic [NUM_PORTS-1:0]               rsp_write_done,
  output logic                               timeout,
  output logic [1:0]                         command,
  output logic [ADDRESS_WIDTH-1:0]           data_address,
  output logic [DATA_WIDTH-1:0]              data_write,
  input  logic [DATA_WIDTH-1:0]              data_read,
  input  logic                               data_read_valid,
  input  logic                               data_write_done
);

  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BEAT_W = $clog2(READ_BURST_LENGTH + 1);
  localparam int WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0]        CMD_NOP   = 2'b00;
  localparam logic [1:0]        CMD_WRITE = 2'b01;
  localparam logic [1:0]        CMD_READ  = 2'b10;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(READ_BURST_LENGTH - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [PTR_W-1:0]  LAST_PORT = PTR_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_READ  = 2'd2,
    WAIT_WRITE = 2'd3
  } state_t;

  state_t                    state_q,    state_d;
  logic [PTR_W-1:0]          grant_q,    grant_d;
  logic [PTR_W-1:0]          rr_ptr_q,   rr_ptr_d;
  logic                      is_write_q, is_write_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q,     addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q,    wdata_d;
  logic [BEAT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic [WD_W-1:0]           wd_cnt_q,   wd_cnt_d;
  logic [1:0]                command_q,  command_d;

  logic                      any_valid;
  logic [PTR_W-1:0]          pick;
  logic [PTR_W:0]            cand;
  logic                      completion;

  // First requesting port at or after rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    any_valid = 1'b0;
    pick      = '0;
    cand      = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_PORTS)) begin
        cand = cand - (PTR_W+1)'(NUM_PORTS);
      end
      if (!any_valid && req_valid[cand[PTR_W-1:0]]) begin
        any_valid = 1'b1;
        pick      = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_ptr_d       = rr_ptr_q;
    is_write_d     = is_write_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    beat_cnt_d     = beat_cnt_q;
    wd_cnt_d       = wd_cnt_q;
    command_d      = CMD_NOP;
    req_ready      = '0;
    rsp_read_valid = '0;
    rsp_write_done = '0;
    timeout        = 1'b0;
    completion     = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready[pick] = 1'b1;
          grant_d         = pick;
          is_write_d      = req_write[pick];
          addr_d          = req_address[int'(pick)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          wdata_d         = req_data[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          rr_ptr_d        = (pick == LAST_PORT) ? '0 : pick + 1'b1;
          command_d       = req_write[pick] ? CMD_WRITE : CMD_READ;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        beat_cnt_d = '0;
        wd_cnt_d   = '0;
        state_d    = is_write_q ? WAIT_WRITE : WAIT_READ;
      end
      WAIT_READ: begin
        if (data_read_valid) begin
          completion              = 1'b1;
          rsp_read_valid[grant_q] = 1'b1;
          beat_cnt_d              = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = IDLE;
          end
        end
      end
      WAIT_WRITE: begin
        if (data_write_done) begin
          completion              = 1'b1;
          rsp_write_done[grant_q] = 1'b1;
          state_d                 = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A beat or done in the expiry cycle wins over the watchdog.
    if ((TIMEOUT_CYCLES > 0) && !completion &&
        (state_q == WAIT_READ || state_q == WAIT_WRITE)) begin
      if (wd_cnt_q == WD_LIMIT) begin
        timeout = 1'b1;
        state_d = IDLE;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      beat_cnt_q <= '0;
      wd_cnt_q   <= '0;
      command_q  <= CMD_NOP;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      beat_cnt_q <= beat_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      command_q  <= command_d;
    end
  end

  assign command      = command_q;
  assign data_address = addr_q;
  assign data_write   = wdata_q;
  assign rsp_data     = data_read;

endmodule
`default_nettype wire

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Round-robin arbiter that shares one `sdram_controller` command/data port between `NUM_PORTS` independent requesters.
- Each requester presents single read or write transactions with a valid/ready handshake.
- The arbiter serialises them onto the controller's `command`/`data_address`/`data_write` inputs and routes `data_read_valid`/`data_write_done` back to the owning requester.
- One transaction is outstanding at a time. A watchdog recovers from a missing completion.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesters (2..8).
- `ADDRESS_WIDTH`, 22: width of request and downstream address.
- `DATA_WIDTH`, 16: data width.
- `READ_BURST_LENGTH`, 1: `data_read_valid` beats per read (1, 2, 4, 8); must equal the controller's setting.
- `TIMEOUT_CYCLES`, 1024: cycles in a wait state before forced abort; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NUM_PORTS  per-port request valid.
- `req_write`  in  NUM_PORTS  1 = write, 0 = read.
- `req_address`  in  NUM_PORTS×ADDRESS_WIDTH  per-port address.
- `req_data`  in  NUM_PORTS×DATA_WIDTH  per-port write data.
- `req_ready`  out  NUM_PORTS  one-hot accept strobe.
- `rsp_data`  out  DATA_WIDTH  read data, shared by all ports.
- `rsp_read_valid`  out  NUM_PORTS  per-port read beat strobe.
- `rsp_write_done`  out  NUM_PORTS  per-port write completion strobe.
- `timeout`  out  1  one-cycle abort pulse.
- `command`  out  2  to controller: 2'b00 NOP, 2'b01 WRITE, 2'b10 READ; 2'b11 never driven.
- `data_address`  out  ADDRESS_WIDTH  to controller.
- `data_write`  out  DATA_WIDTH  to controller.
- `data_read`  in  DATA_WIDTH  from controller.
- `data_read_valid`  in  1  from controller.
- `data_write_done`  in  1  from controller.

## Operation
- FSM states: IDLE, ISSUE, WAIT_READ, WAIT_WRITE.
- Registers:
  - `grant` (port index).
  - `rr_ptr` (highest-priority port).
  - `is_write`, `addr_q`, `wdata_q`.
  - `beat_cnt`, width $clog2(READ_BURST_LENGTH+1).
  - `wd_cnt`, width $clog2(TIMEOUT_CYCLES+1).
- Arbitration, in IDLE with any `req_valid` set:
  - Choose the first set bit scanning from `rr_ptr` upward, wrapping modulo NUM_PORTS.
  - `req_ready[g]`=1 combinationally in that cycle only.
  - Capture `req_write[g]`, `req_address[g]`, `req_data[g]` into `is_write`, `addr_q`, `wdata_q`.
  - Set `rr_ptr` to g+1, wrapping from NUM_PORTS-1 to 0.
  - Next state ISSUE.
- IDLE with no valid: stay; `rr_ptr` unchanged.
- ISSUE: `command` = WRITE or READ for exactly one cycle. Clear `beat_cnt` and `wd_cnt`. Go to WAIT_WRITE or WAIT_READ.
- WAIT_READ, each cycle with `data_read_valid`=1:
  - `rsp_read_valid[grant]`=1 and `beat_cnt`++.
  - On the READ_BURST_LENGTH-th beat, go to IDLE.
- WAIT_WRITE: `data_write_done`=1 gives `rsp_write_done[grant]`=1 and a transition to IDLE.
- `rsp_data` = `data_read` combinationally at all times. It is meaningful only while an `rsp_read_valid` bit is set.
- `data_address`=`addr_q` and `data_write`=`wdata_q` from registers. Both are held stable from ISSUE until the return to IDLE.
- Watchdog, when TIMEOUT_CYCLES>0: `wd_cnt` increments each WAIT cycle without completion. On reaching TIMEOUT_CYCLES:
  - `timeout`=1 for one cycle and go to IDLE.
  - No `rsp_*` pulse for the aborted transaction.
- Stray inputs:
  - `data_read_valid`/`data_write_done` in IDLE or ISSUE are ignored and never forwarded.
  - `data_write_done` in WAIT_READ and `data_read_valid` in WAIT_WRITE are ignored.
- A completion in the same cycle the watchdog expires counts as completion: the `rsp_*` pulse is asserted and `timeout` stays 0.
- Requesters hold `req_*` stable until `req_ready`. Deasserting `req_valid` before `req_ready` is legal and simply withdraws the request.

## Timing
- Reset (`reset_n`=0 at a `clk` edge): state IDLE, `rr_ptr`=0, `command`=NOP.
  - `req_ready`, `rsp_read_valid`, `rsp_write_done`, `timeout` = 0.
  - `data_address`, `data_write` = 0.
  - Reset mid-transaction abandons it silently; the controller's late completion is ignored by the IDLE rule.
- Accept in cycle T. `command` valid in T+1. Earliest read beat or write done in T+2. Next accept in the cycle after the completion cycle.
- Minimum 3 cycles per transaction: accept, issue, and a completion in the first WAIT cycle.
- `command`, `data_address`, `data_write` are registered outputs.
- `req_ready`, `rsp_read_valid`, `rsp_write_done`, `rsp_data` are combinational from state and inputs.

## Test plan
- Reset, then port 2 reads 0x00ABC with BL1, controller returns 0x1234 at T+4:
  - `req_ready`=4'b0100 at T; `command`=2'b10 with `data_address`=0x00ABC at T+1.
  - `rsp_read_valid`=4'b0100 with `rsp_data`=0x1234 at T+4.
  - `req_ready` reasserts at T+5.
- All four ports valid continuously, writes, done one cycle after ISSUE: grant order 0,1,2,3,0; each `rsp_write_done` lands on the correct bit; one accept every 3 cycles.
- READ_BURST_LENGTH=4, port 1, beats at T+3, T+5, T+6, T+9: four `rsp_read_valid[1]` pulses; IDLE at T+10; stray `data_read_valid` at T+11 produces no output.
- TIMEOUT_CYCLES=8, write with no `data_write_done`: `timeout` pulses once, 8 cycles after entering WAIT_WRITE; no `rsp_write_done`; next request is accepted normally.
- `reset_n` low during WAIT_READ, then `data_read_valid` after release: all outputs 0, no `rsp_read_valid`, `rr_ptr` restarts at port 0.
- Port 3 withdraws `req_valid` while port 0 is being served, then port 3 and port 1 request together with `rr_ptr`=1: port 1 is granted first.
